// File: rtl/riscv_pkg.sv
// Shared encodings for the single-cycle RV32I-subset core.
package riscv_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [2:0] F3_ADD_SUB = 3'b000;
   localparam logic [2:0] F3_SLT     = 3'b010;
   localparam logic [2:0] F3_OR      = 3'b110;
   localparam logic [2:0] F3_AND     = 3'b111;
   localparam logic [2:0] F3_WORD    = 3'b010;
   localparam logic [2:0] F3_BEQ     = 3'b000;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_SUB  = 7'b0100000;

   localparam logic [31:0] NOP_INSTR = 32'h00000013;

   typedef enum logic [2:0] {
      ALU_ADD,
      ALU_SUB,
      ALU_AND,
      ALU_OR,
      ALU_SLT
   } alu_op_t;

endpackage

// File: rtl/data_mem.sv
// 64-word data memory: combinational read, synchronous write.
module data_mem (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [5:0]  addr,
   input  logic [31:0] wd,
   output logic [31:0] rd
);

   logic [31:0] memory [0:63];

   // Clear every word on reset, otherwise store on write enable.
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 64; i++) memory[i] <= '0;
      end else if (we) begin
         memory[addr] <= wd;
      end
   end

   assign rd = memory[addr];

endmodule

// File: rtl/pc.sv
// Program counter register.
module pc (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] pc_next,
   output logic [31:0] pc_out
);

   // Load next PC each edge; synchronous active-low clear to 0.
   always_ff @(posedge clk) begin
      if (!rst) pc_out <= '0;
      else      pc_out <= pc_next;
   end

endmodule

// File: rtl/regfile.sv
// 32x32 register file: two combinational reads, one synchronous write, x0 fixed at 0.
module regfile (
   input  logic        clk,
   input  logic        rst,
   input  logic        we,
   input  logic [4:0]  ra1,
   input  logic [4:0]  ra2,
   input  logic [4:0]  wa,
   input  logic [31:0] wd,
   output logic [31:0] rd1,
   output logic [31:0] rd2
);

   logic [31:0] regs [0:31];

   // Clear all registers on reset, otherwise write port (x0 ignored).
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int unsigned i = 0; i < 32; i++) regs[i] <= '0;
      end else if (we && (wa != 5'd0)) begin
         regs[wa] <= wd;
      end
   end

   assign rd1 = (ra1 == 5'd0) ? '0 : regs[ra1];
   assign rd2 = (ra2 == 5'd0) ? '0 : regs[ra2];

endmodule

// File: rtl/riscv_cpu_top.sv
// Single-cycle RV32I-subset core: ROM fetch, decode, ALU, regfile, data memory.
module riscv_cpu_top
   import riscv_pkg::*;
(
   input logic clk,
   input logic rst
);

   logic [31:0] pc_out, pc_next, instruction;
   logic [31:0] rs1_data, rs2_data, alu_b, alu_result, mem_rdata, wb_data;
   logic [31:0] imm_i, imm_s, imm_b, op_imm;
   logic        zero, branch, reg_we, mem_we, is_load, use_imm;
   alu_op_t     alu_op;

   logic [6:0] opcode, funct7;
   logic [2:0] funct3;

   // Hardwired program ROM; anything past the program reads as NOP.
   always_comb begin
      case (pc_out[31:2])
         30'd0:   instruction = 32'h00500093;
         30'd1:   instruction = 32'h00300113;
         30'd2:   instruction = 32'h002081B3;
         30'd3:   instruction = 32'h40208233;
         30'd4:   instruction = 32'h0020F2B3;
         30'd5:   instruction = 32'h0020E333;
         30'd6:   instruction = 32'h00302A23;
         30'd7:   instruction = 32'h01402383;
         30'd8:   instruction = 32'h00338463;
         30'd9:   instruction = 32'h06300413;
         30'd10:  instruction = 32'h00200493;
         30'd11:  instruction = 32'h00938533;
         30'd12:  instruction = 32'h00000063;
         default: instruction = NOP_INSTR;
      endcase
   end

   assign opcode = instruction[6:0];
   assign funct3 = instruction[14:12];
   assign funct7 = instruction[31:25];

   assign imm_i = {{20{instruction[31]}}, instruction[31:20]};
   assign imm_s = {{20{instruction[31]}}, instruction[31:25], instruction[11:7]};
   assign imm_b = {{19{instruction[31]}}, instruction[31], instruction[7],
                   instruction[30:25], instruction[11:8], 1'b0};

   // Decode control; unsupported encodings fall through as NOP.
   always_comb begin
      reg_we  = 1'b0;
      mem_we  = 1'b0;
      is_load = 1'b0;
      use_imm = 1'b0;
      branch  = 1'b0;
      op_imm  = imm_i;
      alu_op  = ALU_ADD;
      case (opcode)
         OP_R: begin
            reg_we = 1'b1;
            if      (funct7 == F7_BASE && funct3 == F3_ADD_SUB) alu_op = ALU_ADD;
            else if (funct7 == F7_SUB  && funct3 == F3_ADD_SUB) alu_op = ALU_SUB;
            else if (funct7 == F7_BASE && funct3 == F3_AND)     alu_op = ALU_AND;
            else if (funct7 == F7_BASE && funct3 == F3_OR)      alu_op = ALU_OR;
            else if (funct7 == F7_BASE && funct3 == F3_SLT)     alu_op = ALU_SLT;
            else reg_we = 1'b0;
         end
         OP_I: begin
            reg_we  = (funct3 == F3_ADD_SUB);
            use_imm = 1'b1;
         end
         OP_LOAD: begin
            reg_we  = (funct3 == F3_WORD);
            is_load = 1'b1;
            use_imm = 1'b1;
         end
         OP_STORE: begin
            mem_we  = (funct3 == F3_WORD);
            use_imm = 1'b1;
            op_imm  = imm_s;
         end
         OP_BRANCH: begin
            branch = (funct3 == F3_BEQ);
            alu_op = ALU_SUB;
         end
         default: ;
      endcase
   end

   assign alu_b = use_imm ? op_imm : rs2_data;

   // ALU datapath.
   always_comb begin
      case (alu_op)
         ALU_ADD: alu_result = rs1_data + alu_b;
         ALU_SUB: alu_result = rs1_data - alu_b;
         ALU_AND: alu_result = rs1_data & alu_b;
         ALU_OR:  alu_result = rs1_data | alu_b;
         ALU_SLT: alu_result = ($signed(rs1_data) < $signed(alu_b)) ? 32'd1 : 32'd0;
         default: alu_result = '0;
      endcase
   end

   assign zero    = (alu_result == 32'd0);
   assign pc_next = (branch && zero) ? pc_out + imm_b : pc_out + 32'd4;
   assign wb_data = is_load ? mem_rdata : alu_result;

   pc pc_inst (
      .clk     (clk),
      .rst     (rst),
      .pc_next (pc_next),
      .pc_out  (pc_out)
   );

   regfile regfile_inst (
      .clk (clk),
      .rst (rst),
      .we  (reg_we),
      .ra1 (instruction[19:15]),
      .ra2 (instruction[24:20]),
      .wa  (instruction[11:7]),
      .wd  (wb_data),
      .rd1 (rs1_data),
      .rd2 (rs2_data)
   );

   data_mem data_mem_inst (
      .clk  (clk),
      .rst  (rst),
      .we   (mem_we),
      .addr (alu_result[7:2]),
      .wd   (rs2_data),
      .rd   (mem_rdata)
   );

endmodule

// File: tb/tb_riscv_cpu_top.sv
// Bench for riscv_cpu_top: directed program checkpoints plus random resets
// compared against an instruction-level interpreter of the same ROM.
module tb_riscv_cpu_top;

   logic clk;
   logic rst;

   int total = 0;
   int bad   = 0;

   logic [31:0] prog [0:12];
   logic [31:0] mpc;
   logic [31:0] mregs [0:31];
   logic [31:0] mmem  [0:63];

   riscv_cpu_top dut (
      .clk (clk),
      .rst (rst)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%08h expected=%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] rom_word(input logic [31:0] addr);
      logic [31:0] idx;
      idx = addr >> 2;
      if (idx < 13) return prog[idx];
      return 32'h00000013;
   endfunction

   // Architectural interpreter: executes one instruction per call.
   task automatic model_step(input logic r);
      logic [31:0] ins, a, b, res, npc, imm_i, imm_s, imm_b, ea;
      logic [6:0]  op, f7;
      logic [2:0]  f3;
      logic [4:0]  rd;
      logic        wr;
      if (!r) begin
         mpc = 32'd0;
         for (int i = 0; i < 32; i++) mregs[i] = 32'd0;
         for (int i = 0; i < 64; i++) mmem[i] = 32'd0;
         return;
      end
      ins   = rom_word(mpc);
      op    = ins[6:0];
      rd    = ins[11:7];
      f3    = ins[14:12];
      f7    = ins[31:25];
      a     = mregs[ins[19:15]];
      b     = mregs[ins[24:20]];
      imm_i = $signed(ins) >>> 20;
      imm_s = (($signed(ins) >>> 25) <<< 5) | 32'(ins[11:7]);
      imm_b = (($signed(ins) >>> 31) <<< 12) | (32'(ins[7]) << 11)
            | (32'(ins[30:25]) << 5) | (32'(ins[11:8]) << 1);
      npc   = mpc + 32'd4;
      wr    = 1'b0;
      res   = 32'd0;
      case (op)
         7'h33: begin
            wr = 1'b1;
            if      (f7 == 7'h00 && f3 == 3'd0) res = a + b;
            else if (f7 == 7'h20 && f3 == 3'd0) res = a - b;
            else if (f7 == 7'h00 && f3 == 3'd7) res = a & b;
            else if (f7 == 7'h00 && f3 == 3'd6) res = a | b;
            else if (f7 == 7'h00 && f3 == 3'd2) res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            else wr = 1'b0;
         end
         7'h13: if (f3 == 3'd0) begin wr = 1'b1; res = a + imm_i; end
         7'h03: if (f3 == 3'd2) begin
            ea  = a + imm_i;
            wr  = 1'b1;
            res = mmem[(ea >> 2) % 64];
         end
         7'h23: if (f3 == 3'd2) begin
            ea = a + imm_s;
            mmem[(ea >> 2) % 64] = b;
         end
         7'h63: if (f3 == 3'd0 && a == b) npc = mpc + imm_b;
         default: ;
      endcase
      if (wr && rd != 5'd0) mregs[rd] = res;
      mpc = npc;
   endtask

   task automatic compare_model();
      logic [31:0] ins;
      ins = rom_word(mpc);
      check_eq("pc", dut.pc_inst.pc_out, mpc);
      check_eq("instruction", dut.instruction, ins);
      check_eq("branch", 32'(dut.branch), 32'(ins[6:0] == 7'h63 && ins[14:12] == 3'd0));
      for (int i = 1; i <= 10; i++)
         check_eq($sformatf("x%0d", i), dut.regfile_inst.regs[i], mregs[i]);
      check_eq("mem5", dut.data_mem_inst.memory[5], mmem[5]);
   endtask

   task automatic tick(input logic r);
      rst = r;
      @(posedge clk);
      model_step(r);
      #1;
      compare_model();
   endtask

   task automatic check_cleared(input string tag);
      check_eq({tag, "_pc"}, dut.pc_inst.pc_out, 32'd0);
      for (int i = 0; i < 32; i++)
         check_eq($sformatf("%s_x%0d", tag, i), dut.regfile_inst.regs[i], 32'd0);
      for (int i = 0; i < 64; i++)
         check_eq($sformatf("%s_mem%0d", tag, i), dut.data_mem_inst.memory[i], 32'd0);
   endtask

   initial begin
      prog[0]  = 32'h00500093; prog[1]  = 32'h00300113; prog[2]  = 32'h002081B3;
      prog[3]  = 32'h40208233; prog[4]  = 32'h0020F2B3; prog[5]  = 32'h0020E333;
      prog[6]  = 32'h00302A23; prog[7]  = 32'h01402383; prog[8]  = 32'h00338463;
      prog[9]  = 32'h06300413; prog[10] = 32'h00200493; prog[11] = 32'h00938533;
      prog[12] = 32'h00000063;
      rst = 1'b0;

      // Reset held for two edges
      tick(1'b0);
      tick(1'b0);
      check_cleared("rst");
      check_eq("first_instr", dut.instruction, 32'h00500093);

      // Arithmetic block
      repeat (6) tick(1'b1);
      check_eq("a_x1", dut.regfile_inst.regs[1], 32'd5);
      check_eq("a_x2", dut.regfile_inst.regs[2], 32'd3);
      check_eq("a_x3", dut.regfile_inst.regs[3], 32'd8);
      check_eq("a_x4", dut.regfile_inst.regs[4], 32'd2);
      check_eq("a_x5", dut.regfile_inst.regs[5], 32'd1);
      check_eq("a_x6", dut.regfile_inst.regs[6], 32'd7);

      // Store then load
      repeat (2) tick(1'b1);
      check_eq("ls_mem5", dut.data_mem_inst.memory[5], 32'd8);
      check_eq("ls_x7", dut.regfile_inst.regs[7], 32'd8);

      // Taken branch at PC 32
      check_eq("br_pc", dut.pc_inst.pc_out, 32'd32);
      check_eq("br_rs1", dut.rs1_data, 32'd8);
      check_eq("br_rs2", dut.rs2_data, 32'd8);
      check_eq("br_alu", dut.alu_result, 32'd0);
      check_eq("br_zero", 32'(dut.zero), 32'd1);
      check_eq("br_branch", 32'(dut.branch), 32'd1);
      tick(1'b1);
      check_eq("br_next_pc", dut.pc_inst.pc_out, 32'd40);
      check_eq("br_x8", dut.regfile_inst.regs[8], 32'd0);

      // Completion at 40 cycles after release, then halt stability
      repeat (31) tick(1'b1);
      check_eq("done_x9", dut.regfile_inst.regs[9], 32'd2);
      check_eq("done_x10", dut.regfile_inst.regs[10], 32'd10);
      check_eq("done_pc", dut.pc_inst.pc_out, 32'd48);
      check_eq("done_x8", dut.regfile_inst.regs[8], 32'd0);
      repeat (3) tick(1'b1);
      check_eq("halt_pc", dut.pc_inst.pc_out, 32'd48);
      check_eq("halt_x10", dut.regfile_inst.regs[10], 32'd10);

      // Mid-run reset: restart, drop rst after 8 cycles for one edge
      tick(1'b0);
      repeat (8) tick(1'b1);
      tick(1'b0);
      check_cleared("mid");
      repeat (40) tick(1'b1);
      check_eq("mid_x10", dut.regfile_inst.regs[10], 32'd10);
      check_eq("mid_pc", dut.pc_inst.pc_out, 32'd48);

      // Random reset pulses against the interpreter
      for (int n = 0; n < 300; n++)
         tick(($urandom_range(0, 14) != 0) ? 1'b1 : 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
